// File: rtl/kmeans_pkg.sv
// Shared constants, state encoding and element packing for the k=2, d=4
// centroid update block.
package kmeans_pkg;

  localparam int K  = 2;
  localparam int D  = 4;
  localparam int NE = K * D;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DIVIDE  = 2'd1,
    PUBLISH = 2'd2
  } state_e;

  // Flat position of centroid k, dimension dd in the packed centroid vectors.
  function automatic int elem_idx(input int k, input int dd);
    return k * D + dd;
  endfunction

endpackage

// File: rtl/kmeans_seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, W cycles after the
// start cycle. done_o and quot_o are valid together in the final iteration.
module kmeans_seq_divider #(
  parameter int W  = 32,
  parameter int QW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [W-1:0]  dividend_i,
  input  logic [W-1:0]  divisor_i,
  output logic          done_o,
  output logic [QW-1:0] quot_o
);

  localparam int CW = $clog2(W + 1);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [W:0]    rem_sh, diff;
  logic [W-1:0]  rem_nx, quo_nx;

  // Bit W of the trial difference is the borrow: set means the divisor didn't fit.
  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    rem_nx = rem_sh[W-1:0];
    quo_nx = {quo_q[W-2:0], 1'b0};
    if (!diff[W]) begin
      rem_nx = diff[W-1:0];
      quo_nx = {quo_q[W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(W);
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  assign done_o = busy_q && (cnt_q == CW'(1));
  assign quot_o = quo_nx[QW-1:0];

endmodule

// File: rtl/kmeans_centroid_update_k2_d4.sv
// k-means centroid update (k=2, d=4): accumulates classified points, then
// divides sums by counts serially and publishes. KMEANS_UPDATE_ROUND_EN selects round-half-up means.
module kmeans_centroid_update_k2_d4
  import kmeans_pkg::*;
#(
  parameter int input_data_width  = 16,
  parameter int centroid_id_width = 1,
  parameter int count_width       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [4*input_data_width-1:0] in_data,
  input  logic [centroid_id_width-1:0]  in_centroid,
  input  logic                          init_load,
  input  logic [8*input_data_width-1:0] centroid_init,
  output logic [8*input_data_width-1:0] centroid_out,
  output logic                          out_valid,
  output logic                          out_changed,
  output logic                          overflow
);

  localparam int sum_width = input_data_width + count_width;
`ifdef KMEANS_UPDATE_ROUND_EN
  localparam int DW = sum_width + 1;
`else
  localparam int DW = sum_width;
`endif

  state_e state_q, state_d;
  logic [2:0] elem_q, elem_d;
  logic       started_q, started_d;
  logic       ovf_q, ovf_d;
  logic       adv;

  logic [K-1:0][D-1:0][input_data_width-1:0] cen_q, cen_d, shd_q, shd_d;
  logic [K-1:0][D-1:0][sum_width-1:0]        sum_q, sum_d;
  logic [K-1:0][count_width-1:0]             cnt_q, cnt_d;

  logic                        k_in, k_e;
  logic [1:0]                  dd_e;
  logic                        div_start, div_done;
  logic [DW-1:0]               dvd, dvs;
  logic [input_data_width-1:0] quot;

  assign k_in = in_centroid[0];
  assign k_e  = elem_q[2];
  assign dd_e = elem_q[1:0];
  assign dvs  = DW'(cnt_q[k_e]);
`ifdef KMEANS_UPDATE_ROUND_EN
  assign dvd  = DW'(sum_q[k_e][dd_e]) + DW'(cnt_q[k_e] >> 1);
`else
  assign dvd  = sum_q[k_e][dd_e];
`endif

  kmeans_seq_divider #(.W(DW), .QW(input_data_width)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start),
    .dividend_i(dvd),
    .divisor_i (dvs),
    .done_o    (div_done),
    .quot_o    (quot)
  );

  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    started_d = started_q;
    ovf_d     = ovf_q;
    cen_d     = cen_q;
    shd_d     = shd_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    div_start = 1'b0;
    adv       = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = !init_load;
        if (init_load) begin
          cen_d = centroid_init;
          sum_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (in_valid) begin
          // A saturated counter drops the point but still honours in_last.
          if (&cnt_q[k_in]) begin
            ovf_d = 1'b1;
          end else begin
            for (int dd = 0; dd < D; dd++)
              sum_d[k_in][dd] = sum_q[k_in][dd] +
                                sum_width'(in_data[dd*input_data_width +: input_data_width]);
            cnt_d[k_in] = cnt_q[k_in] + count_width'(1);
          end
          if (in_last) begin
            state_d   = DIVIDE;
            elem_d    = '0;
            started_d = 1'b0;
          end
        end
      end
      DIVIDE: begin
        if (cnt_q[k_e] == '0) begin
          shd_d[k_e][dd_e] = cen_q[k_e][dd_e];
          adv              = 1'b1;
        end else if (!started_q) begin
          div_start = 1'b1;
          started_d = 1'b1;
        end else if (div_done) begin
          shd_d[k_e][dd_e] = quot;
          started_d        = 1'b0;
          adv              = 1'b1;
        end
        if (adv) begin
          if (elem_q == 3'(NE - 1)) state_d = PUBLISH;
          else                      elem_d  = elem_q + 3'd1;
        end
      end
      PUBLISH: begin
        cen_d   = shd_q;
        sum_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      elem_q    <= '0;
      started_q <= 1'b0;
      ovf_q     <= 1'b0;
      cen_q     <= '0;
      shd_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      started_q <= started_d;
      ovf_q     <= ovf_d;
      cen_q     <= cen_d;
      shd_q     <= shd_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
    end
  end

  for (genvar k = 0; k < K; k++) begin : g_k
    for (genvar dd = 0; dd < D; dd++) begin : g_d
      assign centroid_out[elem_idx(k, dd)*input_data_width +: input_data_width] = cen_q[k][dd];
    end
  end

  assign out_valid   = (state_q == PUBLISH);
  assign out_changed = out_valid && (shd_q != cen_q);
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_kmeans_centroid_update_k2_d4.sv
// Directed bench for kmeans_centroid_update_k2_d4; expectations follow
// KMEANS_UPDATE_ROUND_EN when it is defined.
module tb_kmeans_centroid_update_k2_d4;

`ifdef KMEANS_UPDATE_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int CPE  = 32 + 1 + RND;  // cycles per divided element, count_width=16
  localparam int CPE2 = 18 + 1 + RND;  // same, count_width=2

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_last, init_load;
  logic [63:0]  in_data;
  logic [0:0]   in_centroid;
  logic [127:0] centroid_init, centroid_out;
  logic         out_valid, out_changed, overflow;

  logic         b_valid, b_ready, b_last;
  logic [63:0]  b_data;
  logic [0:0]   b_centroid;
  logic [127:0] b_cout;
  logic         b_ovalid, b_changed, b_ovf;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  kmeans_centroid_update_k2_d4 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_data(in_data), .in_centroid(in_centroid), .init_load(init_load),
    .centroid_init(centroid_init), .centroid_out(centroid_out), .out_valid(out_valid),
    .out_changed(out_changed), .overflow(overflow)
  );

  kmeans_centroid_update_k2_d4 #(.count_width(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_last(b_last),
    .in_data(b_data), .in_centroid(b_centroid), .init_load(1'b0),
    .centroid_init(128'd0), .centroid_out(b_cout), .out_valid(b_ovalid),
    .out_changed(b_changed), .overflow(b_ovf)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int v);
    logic [15:0] x;
    x = 16'(v);
    return {x, x, x, x};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic c, input logic l);
    in_valid = 1'b1; in_data = d; in_centroid = c; in_last = l;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send2(input logic [63:0] d, input logic c, input logic l);
    b_valid = 1'b1; b_data = d; b_centroid = c; b_last = l;
    tick();
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  // lat counts cycles from the accept cycle of the last point to out_valid.
  task automatic wait_pub(input logic sat, output int lat);
    lat = 1;
    while (!(sat ? b_ovalid : out_valid) && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int  lat;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_centroid = '0;
    init_load = 1'b0; centroid_init = '0;
    b_valid = 1'b0; b_last = 1'b0; b_data = '0; b_centroid = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_cout", centroid_out, 128'd0);
    chk("rst_vld", out_valid, 0);
    chk("rst_rdy", in_ready, 1);
    chk("rst_ovf", overflow, 0);

    // Two points averaging to (10,10,10,10) on k0.
    init_load = 1'b1; centroid_init = {pk(100), pk(10)};
    tick();
    init_load = 1'b0;
    chk("init_cout", centroid_out, {pk(100), pk(10)});
    send({16'd6, 16'd10, 16'd12, 16'd8}, 1'b0, 1'b0);
    send({16'd14, 16'd10, 16'd8, 16'd12}, 1'b0, 1'b1);
    wait_pub(1'b0, lat);
    chk("t2_lat", lat, 1 + 4*CPE + 4);
    chk("t2_chg", out_changed, 0);
    chk("t2_hold", centroid_out, {pk(100), pk(10)});
    tick();
    chk("t2_cout", centroid_out, {pk(100), pk(10)});
    chk("t2_vld_off", out_valid, 0);

    // Mean of 1 and 2: floor 1, rounded 2.
    send(pk(1), 1'b1, 1'b0);
    send(pk(2), 1'b1, 1'b1);
    wait_pub(1'b0, lat);
    chk("t3_lat", lat, 1 + 4 + 4*CPE);
    chk("t3_chg", out_changed, 1);
    tick();
    chk("t3_cout", centroid_out, {pk(RND ? 2 : 1), pk(10)});

    // A point offered alongside init_load is refused.
    in_valid = 1'b1; in_data = pk(30); in_centroid = 1'b0;
    init_load = 1'b1; centroid_init = {pk(50), pk(20)};
    #1;
    chk("t4_rdy", in_ready, 0);
    tick();
    in_valid = 1'b0; init_load = 1'b0;
    chk("t4_init", centroid_out, {pk(50), pk(20)});
    send(pk(2), 1'b0, 1'b0);
    send(pk(4), 1'b0, 1'b1);
    wait_pub(1'b0, lat);
    chk("t4_lat", lat, 1 + 4*CPE + 4);
    tick();
    chk("t4_cout", centroid_out, {pk(50), pk(3)});

    // Reset in the middle of a divide abandons the epoch.
    send(pk(9), 1'b0, 1'b1);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_cout", centroid_out, 128'd0);
    chk("t5_rdy", in_ready, 1);
    seen = 1'b0;
    repeat (200) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("t5_nopulse", seen, 0);

    // 2-bit counters saturate at 3; points four and five are dropped.
    for (int i = 0; i < 5; i++) send2(pk(4), 1'b1, i == 4);
    chk("t6_ovf", b_ovf, 1);
    wait_pub(1'b1, lat);
    chk("t6_lat", lat, 1 + 4 + 4*CPE2);
    chk("t6_ovf_pub", b_ovf, 1);
    tick();
    chk("t6_cout", b_cout, {pk(4), 64'd0});
    chk("t6_ovf_clr", b_ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
